// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID-side inputs, flush/hold controls, stall feedback and registered EX-side outputs.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
);
  logic               id_valid;
  logic [RADDR_W-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0]  id_rdata1, id_rdata2, id_imm, id_pc4;
  logic               id_wen, id_alusrc, id_regdst, id_memwrite, id_memread;
  logic               id_memtoreg, id_branch, id_jump, id_jal, id_jr;
  logic [2:0]         id_aluop;
  logic               flush_in, hold_in, stall_out;
  logic               ex_valid;
  logic               ex_wen, ex_alusrc, ex_regdst, ex_memwrite, ex_memread;
  logic               ex_memtoreg, ex_branch, ex_jump, ex_jal, ex_jr;
  logic [2:0]         ex_aluop;
  logic [DATA_W-1:0]  ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic [RADDR_W-1:0] ex_rs, ex_rt, ex_dest;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4,
           id_wen, id_alusrc, id_regdst, id_memwrite, id_memread, id_memtoreg,
           id_branch, id_jump, id_jal, id_jr, id_aluop, flush_in, hold_in,
    input  stall_out, ex_valid, ex_wen, ex_alusrc, ex_regdst, ex_memwrite, ex_memread,
           ex_memtoreg, ex_branch, ex_jump, ex_jal, ex_jr, ex_aluop,
           ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_dest
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4,
           id_wen, id_alusrc, id_regdst, id_memwrite, id_memread, id_memtoreg,
           id_branch, id_jump, id_jal, id_jr, id_aluop, flush_in, hold_in,
    output stall_out, ex_valid, ex_wen, ex_alusrc, ex_regdst, ex_memwrite, ex_memread,
           ex_memtoreg, ex_branch, ex_jump, ex_jal, ex_jr, ex_aluop,
           ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_dest
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Optional ID_EX_HAZARD_STATS_EN adds saturating stall/flush event counters.
module id_ex_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [15:0]  stat_stall_cnt,
  output logic [15:0]  stat_flush_cnt
`endif
);

  typedef struct packed {
    logic       wen, alusrc, regdst, memwrite, memread;
    logic       memtoreg, branch, jump, jal, jr;
    logic [2:0] aluop;
  } ctrl_t;

  typedef enum logic [1:0] {ACT_CAPTURE, ACT_FLUSH, ACT_HOLD, ACT_BUBBLE} act_e;

  logic               valid_q, valid_d;
  ctrl_t              ctrl_q, ctrl_d, id_ctrl;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [DATA_W-1:0]  imm_q, imm_d, pc4_q, pc4_d;
  logic [RADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d, id_dest;
  logic               reads_rs, reads_rt, load_use;
  act_e               act;

  assign id_ctrl = '{wen: bus.id_wen, alusrc: bus.id_alusrc, regdst: bus.id_regdst,
                     memwrite: bus.id_memwrite, memread: bus.id_memread,
                     memtoreg: bus.id_memtoreg, branch: bus.id_branch, jump: bus.id_jump,
                     jal: bus.id_jal, jr: bus.id_jr, aluop: bus.id_aluop};

  assign id_dest  = bus.id_jal ? RADDR_W'(LINK_REG) : (bus.id_alusrc ? bus.id_rt : bus.id_rd);
  assign reads_rs = !(bus.id_jump & !bus.id_jr);
  assign reads_rt = !bus.id_alusrc | bus.id_memwrite | bus.id_branch;
  assign load_use = bus.id_valid & valid_q & ctrl_q.memread & (dest_q != '0) &
                    ((reads_rs & (bus.id_rs == dest_q)) | (reads_rt & (bus.id_rt == dest_q)));

  // Gated by rst so the stall is quiet while reset holds, even if hold_in is high.
  assign bus.stall_out = !rst & !bus.flush_in & (bus.hold_in | load_use);

  always_comb begin
    act = ACT_CAPTURE;
    if (bus.flush_in)     act = ACT_FLUSH;
    else if (bus.hold_in) act = ACT_HOLD;
    else if (load_use)    act = ACT_BUBBLE;
  end

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    pc4_d    = pc4_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    dest_d   = dest_q;
    unique case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d  = 1'b0;
        ctrl_d   = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        pc4_d    = '0;
        rs_d     = '0;
        rt_d     = '0;
        dest_d   = '0;
      end
      ACT_HOLD: ;
      ACT_CAPTURE: begin
        valid_d  = bus.id_valid;
        ctrl_d   = bus.id_valid ? id_ctrl : '0;
        rdata1_d = bus.id_rdata1;
        rdata2_d = bus.id_rdata2;
        imm_d    = bus.id_imm;
        pc4_d    = bus.id_pc4;
        rs_d     = bus.id_rs;
        rt_d     = bus.id_rt;
        dest_d   = id_dest;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      dest_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      pc4_q    <= pc4_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      dest_q   <= dest_d;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_wen      = ctrl_q.wen;
  assign bus.ex_alusrc   = ctrl_q.alusrc;
  assign bus.ex_regdst   = ctrl_q.regdst;
  assign bus.ex_memwrite = ctrl_q.memwrite;
  assign bus.ex_memread  = ctrl_q.memread;
  assign bus.ex_memtoreg = ctrl_q.memtoreg;
  assign bus.ex_branch   = ctrl_q.branch;
  assign bus.ex_jump     = ctrl_q.jump;
  assign bus.ex_jal      = ctrl_q.jal;
  assign bus.ex_jr       = ctrl_q.jr;
  assign bus.ex_aluop    = ctrl_q.aluop;
  assign bus.ex_rdata1   = rdata1_q;
  assign bus.ex_rdata2   = rdata2_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_pc4      = pc4_q;
  assign bus.ex_rs       = rs_q;
  assign bus.ex_rt       = rt_q;
  assign bus.ex_dest     = dest_q;

`ifdef ID_EX_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (act == ACT_BUBBLE && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (act == ACT_FLUSH && flush_cnt_q != '1)  flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; stat counters are checked when ID_EX_HAZARD_STATS_EN is defined.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .RADDR_W(5)) bus ();
`ifdef ID_EX_HAZARD_STATS_EN
  logic [15:0] stat_stall_cnt, stat_flush_cnt;
`endif

  id_ex_stage #(.DATA_W(32), .RADDR_W(5), .LINK_REG(31)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef ID_EX_HAZARD_STATS_EN
    ,
    .stat_stall_cnt(stat_stall_cnt),
    .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rdata1 = 0; bus.id_rdata2 = 0; bus.id_imm = 0; bus.id_pc4 = 0;
    bus.id_wen = 0; bus.id_alusrc = 0; bus.id_regdst = 0; bus.id_memwrite = 0;
    bus.id_memread = 0; bus.id_memtoreg = 0; bus.id_branch = 0; bus.id_jump = 0;
    bus.id_jal = 0; bus.id_jr = 0; bus.id_aluop = 0;
    bus.flush_in = 0; bus.hold_in = 0;
  endtask

  task automatic drive_add(input logic [4:0] rs, rt, rd, input logic [31:0] r1, r2);
    clear_id();
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rdata1 = r1; bus.id_rdata2 = r2; bus.id_wen = 1; bus.id_regdst = 1;
    bus.id_pc4 = 32'h40;
  endtask

  task automatic drive_lw(input logic [4:0] rs, rt);
    clear_id();
    bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_imm = 32'h8;
    bus.id_wen = 1; bus.id_alusrc = 1; bus.id_memread = 1; bus.id_memtoreg = 1;
  endtask

  task automatic test_reset();
    clear_id();
    rst = 1;
    #12 rst = 0;
    #1;
    n_total++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.stall_out} !== 8'h00)
      $display("FAIL reset_release got=%0h exp=0", {bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.stall_out});
    else n_pass++;
    drive_add(5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_wen} !== 2'b11) $display("FAIL reset_precond got=%b exp=11", {bus.ex_valid, bus.ex_wen});
    else n_pass++;
    bus.hold_in = 1;
    #2 rst = 1;
    #1;
    n_total++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.ex_rdata1} !== 39'd0)
      $display("FAIL reset_async got=%0h exp=0", {bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.ex_rdata1});
    else n_pass++;
    n_total++;
    if (bus.stall_out !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stall_out);
    else n_pass++;
    #1 rst = 0;
    clear_id();
  endtask

  task automatic test_add();
    drive_add(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    #1;
    n_total++;
    if (bus.stall_out !== 1'b0) $display("FAIL add_stall got=%b exp=0", bus.stall_out);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.ex_aluop} !== {1'b1, 1'b1, 5'd3, 3'd0})
      $display("FAIL add_ctrl got=%0h exp=%0h", {bus.ex_valid, bus.ex_wen, bus.ex_dest, bus.ex_aluop}, {1'b1, 1'b1, 5'd3, 3'd0});
    else n_pass++;
    n_total++;
    if ({bus.ex_rdata1, bus.ex_rdata2} !== {32'd5, 32'd7})
      $display("FAIL add_data got=%0h exp=%0h", {bus.ex_rdata1, bus.ex_rdata2}, {32'd5, 32'd7});
    else n_pass++;
  endtask

  task automatic test_load_use();
    drive_lw(5'd1, 5'd5);
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_memread, bus.ex_dest} !== {1'b1, 1'b1, 5'd5})
      $display("FAIL lw_capture got=%0h exp=%0h", {bus.ex_valid, bus.ex_memread, bus.ex_dest}, {1'b1, 1'b1, 5'd5});
    else n_pass++;
    drive_add(5'd5, 5'd2, 5'd3, 32'h9, 32'hA);
    #1;
    n_total++;
    if (bus.stall_out !== 1'b1) $display("FAIL lu_stall got=%b exp=1", bus.stall_out);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_memread, bus.stall_out} !== 4'b0000)
      $display("FAIL lu_bubble got=%b exp=0000", {bus.ex_valid, bus.ex_wen, bus.ex_memread, bus.stall_out});
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_rs, bus.ex_dest} !== {1'b1, 5'd5, 5'd3})
      $display("FAIL lu_resume got=%0h exp=%0h", {bus.ex_valid, bus.ex_rs, bus.ex_dest}, {1'b1, 5'd5, 5'd3});
    else n_pass++;
`ifdef ID_EX_HAZARD_STATS_EN
    n_total++;
    if (stat_stall_cnt !== 16'd1) $display("FAIL lu_stat got=%0d exp=1", stat_stall_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_no_hazard();
    drive_lw(5'd1, 5'd0);
    tick();
    drive_add(5'd0, 5'd2, 5'd3, 32'h1, 32'h2);
    #1;
    n_total++;
    if (bus.stall_out !== 1'b0) $display("FAIL r0_nostall got=%b exp=0", bus.stall_out);
    else n_pass++;
    drive_lw(5'd1, 5'd5);
    tick();
    clear_id();
    bus.id_valid = 1; bus.id_rs = 5'd6; bus.id_rt = 5'd5; bus.id_alusrc = 1; bus.id_wen = 1;
    #1;
    n_total++;
    if (bus.stall_out !== 1'b0) $display("FAIL addi_nostall got=%b exp=0", bus.stall_out);
    else n_pass++;
    bus.id_wen = 0; bus.id_memwrite = 1;
    #1;
    n_total++;
    if (bus.stall_out !== 1'b1) $display("FAIL sw_rt_stall got=%b exp=1", bus.stall_out);
    else n_pass++;
  endtask

  task automatic test_flush();
    drive_lw(5'd1, 5'd5);
    tick();
    drive_add(5'd5, 5'd2, 5'd3, 32'h9, 32'hA);
    bus.flush_in = 1;
    #1;
    n_total++;
    if (bus.stall_out !== 1'b0) $display("FAIL flush_stall got=%b exp=0", bus.stall_out);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_memread} !== 3'b000)
      $display("FAIL flush_bubble got=%b exp=000", {bus.ex_valid, bus.ex_wen, bus.ex_memread});
    else n_pass++;
`ifdef ID_EX_HAZARD_STATS_EN
    n_total++;
    if ({stat_flush_cnt, stat_stall_cnt} !== {16'd1, 16'd1})
      $display("FAIL flush_stat got=%0d/%0d exp=1/1", stat_flush_cnt, stat_stall_cnt);
    else n_pass++;
`endif
    drive_add(5'd1, 5'd2, 5'd3, 32'h9, 32'hA);
    tick();
    bus.flush_in = 1; bus.hold_in = 1;
    #1;
    n_total++;
    if (bus.stall_out !== 1'b0) $display("FAIL flushhold_stall got=%b exp=0", bus.stall_out);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_wen} !== 2'b00) $display("FAIL flushhold_bubble got=%b exp=00", {bus.ex_valid, bus.ex_wen});
    else n_pass++;
  endtask

  task automatic test_nop();
    clear_id();
    bus.id_wen = 1; bus.id_memread = 1; bus.id_rdata1 = 32'h55; bus.id_rd = 5'd4;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_wen, bus.ex_memread, bus.ex_rdata1} !== {3'b000, 32'h55})
      $display("FAIL nop_ctrl got=%0h exp=%0h", {bus.ex_valid, bus.ex_wen, bus.ex_memread, bus.ex_rdata1}, {3'b000, 32'h55});
    else n_pass++;
  endtask

  task automatic test_jal_hold();
    clear_id();
    bus.id_valid = 1; bus.id_jump = 1; bus.id_jal = 1; bus.id_wen = 1;
    bus.id_rd = 5'd7; bus.id_pc4 = 32'h100;
    tick();
    n_total++;
    if ({bus.ex_dest, bus.ex_jal, bus.ex_jump, bus.ex_pc4} !== {5'd31, 1'b1, 1'b1, 32'h100})
      $display("FAIL jal_capture got=%0h exp=%0h", {bus.ex_dest, bus.ex_jal, bus.ex_jump, bus.ex_pc4}, {5'd31, 1'b1, 1'b1, 32'h100});
    else n_pass++;
    drive_add(5'd8, 5'd9, 5'd10, 32'hAA, 32'hBB);
    bus.hold_in = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (bus.stall_out !== 1'b1) $display("FAIL hold_stall[%0d] got=%b exp=1", i, bus.stall_out);
      else n_pass++;
      tick();
      n_total++;
      if ({bus.ex_dest, bus.ex_jal, bus.ex_pc4, bus.ex_rdata1} !== {5'd31, 1'b1, 32'h100, 32'h0})
        $display("FAIL hold_frozen[%0d] got=%0h exp=%0h", i, {bus.ex_dest, bus.ex_jal, bus.ex_pc4, bus.ex_rdata1}, {5'd31, 1'b1, 32'h100, 32'h0});
      else n_pass++;
    end
    bus.hold_in = 0;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_dest, bus.ex_jal, bus.ex_rdata1} !== {1'b1, 5'd10, 1'b0, 32'hAA})
      $display("FAIL hold_release got=%0h exp=%0h", {bus.ex_valid, bus.ex_dest, bus.ex_jal, bus.ex_rdata1}, {1'b1, 5'd10, 1'b0, 32'hAA});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_nop();
    test_jal_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with load-use hazard detection. It sits directly downstream of the decode control unit and register file. It captures decoded control bits, operands, immediate and PC+4 each cycle and presents them to EX. It inserts bubbles on load-use hazards, honours downstream hold and branch/jump flush, and drives the stall back to IF/ID and PC.

Parameters:
DATA_W, 32, operand/immediate/PC width
RADDR_W, 5, register address width
LINK_REG, 31, destination register for JAL

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction (0 = NOP/bubble)
id_rs, id_rt, id_rd  in  RADDR_W each  register fields
id_rdata1, id_rdata2  in  DATA_W each  register file read data
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4 of instruction
id_wen, id_alusrc, id_regdst, id_memwrite, id_memread, id_memtoreg, id_branch, id_jump, id_jal, id_jr  in  1 each  decoded control
id_aluop  in  3  ALU op
flush_in  in  1  squash instruction entering EX (taken branch/jump)
hold_in  in  1  downstream stall; freeze this stage
stall_out  out  1  freeze PC and IF/ID this cycle (combinational)
ex_valid  out  1  registered valid
ex_wen … ex_jr, ex_aluop  out  matching  registered control
ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered data
ex_rs, ex_rt  out  RADDR_W  registered source fields for forwarding
ex_dest  out  RADDR_W  registered write destination

Behaviour:
- Reset: asynchronous. All ex_* outputs go to 0 immediately, including ex_valid and ex_dest. stall_out=0 while rst=1.
- Destination: id_jal ? LINK_REG : (id_alusrc ? id_rt : id_rd). The result is registered into ex_dest.
- Source use: reads_rs = !(id_jump & !id_jr). reads_rt = !id_alusrc | id_memwrite | id_branch.
- load_use = id_valid & ex_valid & ex_memread & ex_dest!=0 & ((reads_rs & id_rs==ex_dest) | (reads_rt & id_rt==ex_dest)).
- stall_out = !flush_in & (hold_in | load_use).
- Per-edge action, in priority order:
  1. flush_in: capture bubble (ex_valid=0, all control bits 0, data don't-care but driven 0).
  2. hold_in: all ex_* registers retain their values.
  3. load_use: capture bubble. ID is held upstream via stall_out.
  4. Otherwise: capture all id_* values. If id_valid=0, control bits are forced to 0.
- Bubble definition: ex_valid=0 and ex_wen=ex_memwrite=ex_memread=ex_branch=ex_jump=ex_jal=ex_jr=0. EX/MEM must treat the slot as NOP.
- A load-use stall lasts exactly 1 cycle. The bubble has ex_memread=0, so the hazard clears on the next cycle unless hold_in is asserted.
- Latency: 1 cycle, ID to EX.
- Reset mid-stall: reset clears ex_valid, so the hazard condition is false after release.
- flush_in together with hold_in: flush wins and the slot is squashed.

Optional Feature:
Macro ID_EX_HAZARD_STATS_EN.
- Defined: adds output ports stat_stall_cnt[15:0] and stat_flush_cnt[15:0].
  - stat_stall_cnt increments on each edge where load_use & !flush_in & !hold_in.
  - stat_flush_cnt increments on each edge where flush_in=1.
  - Both counters saturate at 16'hFFFF and reset asynchronously to 0.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Assert rst while ex_valid=1 and ex_wen=1, mid-clock -> all ex_* outputs go to 0 before the next edge; stall_out=0.
2. ADD rs=1 rt=2 rd=3, rdata1=5, rdata2=7, aluop=0 -> next edge: ex_valid=1, ex_wen=1, ex_dest=3, ex_rdata1=5, ex_rdata2=7, stall_out=0.
3. LW rt=5 (alusrc=1, memread=1), then ADD rs=5 -> stall_out=1 for exactly 1 cycle, ex_valid=0 bubble, then ADD is captured with ex_rs=5. With the stats macro defined: stat_stall_cnt=1.
4. LW rt=0 followed by ADD rs=0 -> no stall. LW rt=5 followed by ADDI rs=6 rt=5 (alusrc=1) -> no stall, since rt is not read.
5. Load-use condition with flush_in=1 in the same cycle -> stall_out=0, ex_valid=0 next edge. With the stats macro defined: stat_flush_cnt=1, stat_stall_cnt unchanged.
6. JAL captured -> ex_dest=31, ex_jal=1, ex_jump=1. Then hold_in=1 for 3 cycles with new ID inputs -> ex_* frozen for 3 edges and stall_out=1; the new instruction is captured on the first edge after hold_in drops.
